// File: rtl/iic_core_arbiter.sv
// iic_core_arbiter
// Shares one I2C master core between two requesters. Round-robin grant in
// IDLE, latches the winner's command onto the core_* outputs, pulses the
// core enable, waits for done or timeout, returns a response to the owner
// and enforces an idle gap before the next grant.
// Build macro IIC_ARB_RETRY_EN: the first timeout of a transaction is
// retried once (same latched fields, no second ack) before an error is
// reported.
module iic_core_arbiter #(
    parameter int TIMEOUT_CYC = 60000,
    parameter int GAP_CYC     = 1000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    input  logic        req0_rd,
    input  logic [6:0]  req0_dev,
    input  logic [12:0] req0_reg,
    input  logic [1:0]  req0_reg_len,
    input  logic [7:0]  req0_wdata,
    output logic        req0_ack,
    output logic        req0_rsp_valid,

    input  logic        req1_valid,
    input  logic        req1_rd,
    input  logic [6:0]  req1_dev,
    input  logic [12:0] req1_reg,
    input  logic [1:0]  req1_reg_len,
    input  logic [7:0]  req1_wdata,
    output logic        req1_ack,
    output logic        req1_rsp_valid,

    output logic        rsp_err,
    output logic [7:0]  rsp_rdata,

    output logic        core_wr_en,
    output logic        core_re_en,
    output logic [6:0]  core_addr_me,
    output logic [12:0] core_addr_reg,
    output logic [1:0]  core_num_reg_add,
    output logic [7:0]  core_num_sent,
    output logic [7:0]  core_num_rece,
    output logic [7:0]  core_wdata,
    input  logic [7:0]  core_rdata,
    input  logic        core_done,

    output logic        busy
);

    // Counter widths: each counter only needs to reach its terminal value N-1.
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [GP_W-1:0] GAP_LAST = GP_W'(GAP_CYC - 1);

    // Sequencer state encoding.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    logic [2:0]      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic            rd_q, rd_d;

    logic [6:0]      addr_me_q, addr_me_d;
    logic [12:0]     addr_reg_q, addr_reg_d;
    logic [1:0]      reg_len_q, reg_len_d;
    logic [7:0]      num_sent_q, num_sent_d;
    logic [7:0]      num_rece_q, num_rece_d;
    logic [7:0]      wdata_q, wdata_d;

    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            rspv0_q, rspv0_d;
    logic            rspv1_q, rspv1_d;
    logic            rsp_err_q, rsp_err_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;
    logic            wr_en_q, wr_en_d;
    logic            re_en_q, re_en_d;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [GP_W-1:0] gap_cnt_q, gap_cnt_d;

`ifdef IIC_ARB_RETRY_EN
    logic            retry_q, retry_d;
    logic            relaunch_q, relaunch_d;
`endif

    // Arbitration: a lone requester wins; on a tie the one not granted last.
    logic            win;
    logic            sel_rd;
    logic [6:0]      sel_dev;
    logic [12:0]     sel_reg;
    logic [1:0]      sel_len;
    logic [7:0]      sel_wdata;

    assign win       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign sel_rd    = win ? req1_rd      : req0_rd;
    assign sel_dev   = win ? req1_dev     : req0_dev;
    assign sel_reg   = win ? req1_reg     : req0_reg;
    assign sel_len   = win ? req1_reg_len : req0_reg_len;
    assign sel_wdata = win ? req1_wdata   : req0_wdata;

    // Next-state, command latching, pulse generation and response capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        rd_d         = rd_q;
        addr_me_d    = addr_me_q;
        addr_reg_d   = addr_reg_q;
        reg_len_d    = reg_len_q;
        num_sent_d   = num_sent_q;
        num_rece_d   = num_rece_q;
        wdata_d      = wdata_q;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        to_cnt_d     = to_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rspv0_d      = 1'b0;
        rspv1_d      = 1'b0;
        wr_en_d      = 1'b0;
        re_en_d      = 1'b0;
`ifdef IIC_ARB_RETRY_EN
        retry_d      = retry_q;
        relaunch_d   = relaunch_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d      = S_LAUNCH;
                    owner_d      = win;
                    last_grant_d = win;
                    rd_d         = sel_rd;
                    addr_me_d    = sel_dev;
                    addr_reg_d   = sel_reg;
                    reg_len_d    = sel_len;
                    wdata_d      = sel_wdata;
                    num_sent_d   = 8'd1;
                    num_rece_d   = 8'd1;
                    // Pulses are registered so they are high during LAUNCH.
                    ack0_d       = ~win;
                    ack1_d       = win;
                    wr_en_d      = ~sel_rd;
                    re_en_d      = sel_rd;
`ifdef IIC_ARB_RETRY_EN
                    retry_d      = 1'b0;
                    relaunch_d   = 1'b0;
`endif
                end
            end

            S_LAUNCH: begin
                state_d  = S_WAIT;
                to_cnt_d = '0;
            end

            S_WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (core_done) begin
                    // Done takes priority over a coincident terminal count.
                    state_d     = S_RESP;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = rd_q ? core_rdata : 8'h00;
                    rspv0_d     = ~owner_q;
                    rspv1_d     = owner_q;
                end else if (to_cnt_q == TO_LAST) begin
`ifdef IIC_ARB_RETRY_EN
                    if (!retry_q) begin
                        // First timeout: silently relaunch after the idle gap.
                        retry_d    = 1'b1;
                        relaunch_d = 1'b1;
                        state_d    = S_GAP;
                        gap_cnt_d  = '0;
                    end else begin
                        state_d     = S_RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 8'h00;
                        rspv0_d     = ~owner_q;
                        rspv1_d     = owner_q;
                    end
`else
                    state_d     = S_RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 8'h00;
                    rspv0_d     = ~owner_q;
                    rspv1_d     = owner_q;
`endif
                end
            end

            S_RESP: begin
                state_d   = S_GAP;
                gap_cnt_d = '0;
            end

            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
`ifdef IIC_ARB_RETRY_EN
                    if (relaunch_q) begin
                        // Relaunch with the latched command; no new ack.
                        state_d    = S_LAUNCH;
                        relaunch_d = 1'b0;
                        wr_en_d    = ~rd_q;
                        re_en_d    = rd_q;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; synchronous reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            rd_q         <= 1'b0;
            addr_me_q    <= '0;
            addr_reg_q   <= '0;
            reg_len_q    <= '0;
            num_sent_q   <= '0;
            num_rece_q   <= '0;
            wdata_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rspv0_q      <= 1'b0;
            rspv1_q      <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            wr_en_q      <= 1'b0;
            re_en_q      <= 1'b0;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
`ifdef IIC_ARB_RETRY_EN
            retry_q      <= 1'b0;
            relaunch_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rd_q         <= rd_d;
            addr_me_q    <= addr_me_d;
            addr_reg_q   <= addr_reg_d;
            reg_len_q    <= reg_len_d;
            num_sent_q   <= num_sent_d;
            num_rece_q   <= num_rece_d;
            wdata_q      <= wdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rspv0_q      <= rspv0_d;
            rspv1_q      <= rspv1_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            wr_en_q      <= wr_en_d;
            re_en_q      <= re_en_d;
            to_cnt_q     <= to_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
`ifdef IIC_ARB_RETRY_EN
            retry_q      <= retry_d;
            relaunch_q   <= relaunch_d;
`endif
        end
    end

    assign req0_ack         = ack0_q;
    assign req1_ack         = ack1_q;
    assign req0_rsp_valid   = rspv0_q;
    assign req1_rsp_valid   = rspv1_q;
    assign rsp_err          = rsp_err_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign core_wr_en       = wr_en_q;
    assign core_re_en       = re_en_q;
    assign core_addr_me     = addr_me_q;
    assign core_addr_reg    = addr_reg_q;
    assign core_num_reg_add = reg_len_q;
    assign core_num_sent    = num_sent_q;
    assign core_num_rece    = num_rece_q;
    assign core_wdata       = wdata_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_iic_core_arbiter.sv
// Directed bench for iic_core_arbiter with a launch/response scoreboard and
// a behavioural I2C core model (programmable done latency and read byte).
`timescale 1ns/1ps
module tb_iic_core_arbiter;

    localparam int T = 40;
    localparam int G = 8;
`ifdef IIC_ARB_RETRY_EN
    localparam int EXP_EN_TO = 2;
`else
    localparam int EXP_EN_TO = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_rd, req1_valid, req1_rd;
    logic [6:0]  req0_dev, req1_dev;
    logic [12:0] req0_reg, req1_reg;
    logic [1:0]  req0_reg_len, req1_reg_len;
    logic [7:0]  req0_wdata, req1_wdata;
    logic        req0_ack, req0_rsp_valid, req1_ack, req1_rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_rdata;
    logic        core_wr_en, core_re_en;
    logic [6:0]  core_addr_me;
    logic [12:0] core_addr_reg;
    logic [1:0]  core_num_reg_add;
    logic [7:0]  core_num_sent, core_num_rece, core_wdata;
    logic [7:0]  core_rdata;
    logic        core_done;
    logic        busy;

    iic_core_arbiter #(.TIMEOUT_CYC(T), .GAP_CYC(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_dev(req0_dev), .req0_reg(req0_reg),
        .req0_reg_len(req0_reg_len), .req0_wdata(req0_wdata), .req0_ack(req0_ack),
        .req0_rsp_valid(req0_rsp_valid),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_dev(req1_dev), .req1_reg(req1_reg),
        .req1_reg_len(req1_reg_len), .req1_wdata(req1_wdata), .req1_ack(req1_ack),
        .req1_rsp_valid(req1_rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .core_wr_en(core_wr_en), .core_re_en(core_re_en), .core_addr_me(core_addr_me),
        .core_addr_reg(core_addr_reg), .core_num_reg_add(core_num_reg_add),
        .core_num_sent(core_num_sent), .core_num_rece(core_num_rece), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_done(core_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic        rd;
        logic [6:0]  dev;
        logic [12:0] rg;
        logic [1:0]  len;
        logic [7:0]  wdata;
        logic        ack;
    } launch_t;

    typedef struct {
        logic       owner;
        logic       err;
        logic [7:0] rdata;
        logic       by_timeout;
    } rsp_t;

    launch_t lq[$];
    rsp_t    rq[$];
    launch_t cur;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cyc = 0;
    int en_cyc = 0;
    int en_cnt = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    int model_dly = 0;
    int model_cnt = 0;
    bit prev_en = 0;
    bit chk_gap = 0;
    bit gap_armed = 0;

    function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: done pulses model_dly cycles after the launch cycle (0 = never).
    always @(negedge clk) begin
        if (!rst_n) begin
            model_cnt = 0;
            core_done = 1'b0;
        end else begin
            core_done = 1'b0;
            if (model_cnt > 0) begin
                model_cnt = model_cnt - 1;
                if (model_cnt == 0) begin
                    core_done = 1'b1;
                    done_cyc  = cyc;
                end
            end
            if (core_wr_en || core_re_en) model_cnt = model_dly;
        end
    end

    // Monitor: compares launches and responses against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_en)
                chk("pulse_width", {core_wr_en, core_re_en, req0_ack, req1_ack}, 0);
            if (core_wr_en || core_re_en) begin
                en_cnt++;
                en_cyc = cyc;
                if (chk_gap && gap_armed) chk("gap_done_to_en", cyc - done_cyc, G + 3);
                gap_armed = 0;
                chk("launch_expected", lq.size() > 0, 1);
                if (lq.size() > 0) begin
                    cur = lq.pop_front();
                    chk("launch_dir", {core_re_en, core_wr_en}, cur.rd ? 2'b10 : 2'b01);
                    chk("launch_ack", {req1_ack, req0_ack},
                        cur.ack ? (cur.owner ? 2'b10 : 2'b01) : 2'b00);
                    chk("launch_fields", {core_addr_me, core_addr_reg, core_num_reg_add, core_wdata},
                        {cur.dev, cur.rg, cur.len, cur.wdata});
                    chk("launch_counts", {core_num_sent, core_num_rece}, 16'h0101);
                    chk("launch_busy", busy, 1);
                end
            end
            if (req0_ack) ack0_cnt++;
            if (req1_ack) ack1_cnt++;
            if (req0_rsp_valid || req1_rsp_valid) begin
                chk("rsp_expected", rq.size() > 0, 1);
                if (rq.size() > 0) begin
                    rsp_t r;
                    r = rq.pop_front();
                    chk("rsp_owner", {req1_rsp_valid, req0_rsp_valid}, r.owner ? 2'b10 : 2'b01);
                    chk("rsp_data", {rsp_err, rsp_rdata}, {r.err, r.rdata});
                    if (r.by_timeout) chk("rsp_timing_timeout", cyc - en_cyc, T + 1);
                    else              chk("rsp_timing_done", cyc - done_cyc, 1);
                    chk("rsp_fields_stable",
                        {core_addr_me, core_addr_reg, core_num_reg_add, core_wdata, core_num_sent},
                        {cur.dev, cur.rg, cur.len, cur.wdata, 8'd1});
                end
                gap_armed = chk_gap;
            end
            prev_en = core_wr_en || core_re_en;
        end else begin
            prev_en = 0;
        end
    end

    task automatic push_l(input bit owner, input bit rd, input logic [6:0] dev,
                          input logic [12:0] rg, input logic [1:0] len, input logic [7:0] wd,
                          input bit ack);
        launch_t e;
        e.owner = owner; e.rd = rd; e.dev = dev; e.rg = rg; e.len = len; e.wdata = wd; e.ack = ack;
        lq.push_back(e);
    endtask

    task automatic push_r(input bit owner, input bit err, input logic [7:0] rdata, input bit to);
        rsp_t e;
        e.owner = owner; e.err = err; e.rdata = rdata; e.by_timeout = to;
        rq.push_back(e);
    endtask

    task automatic post(input bit n, input bit rd, input logic [6:0] dev, input logic [12:0] rg,
                        input logic [1:0] len, input logic [7:0] wd);
        if (!n) begin
            req0_rd = rd; req0_dev = dev; req0_reg = rg; req0_reg_len = len; req0_wdata = wd;
            req0_valid = 1'b1;
        end else begin
            req1_rd = rd; req1_dev = dev; req1_reg = rg; req1_reg_len = len; req1_wdata = wd;
            req1_valid = 1'b1;
        end
    endtask

    task automatic wait_ack(input bit n, input string tag);
        bit got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((!n && req0_ack) || (n && req1_ack)) begin
                got = 1;
                break;
            end
        end
        chk(tag, got, 1);
        if (!n) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy && rq.size() == 0 && lq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(tag, ok, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {busy, core_wr_en, core_re_en, req0_ack, req1_ack,
                            req0_rsp_valid, req1_rsp_valid, rsp_err}, 0);
        chk({tag, "_bus"}, {core_addr_me, core_addr_reg, core_num_reg_add, core_num_sent,
                            core_num_rece, core_wdata, rsp_rdata}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, e0, seen;
        rst_n = 1'b0;
        req0_valid = 0; req0_rd = 0; req0_dev = '0; req0_reg = '0; req0_reg_len = '0; req0_wdata = '0;
        req1_valid = 0; req1_rd = 0; req1_dev = '0; req1_reg = '0; req1_reg_len = '0; req1_wdata = '0;
        core_rdata = 8'h00;
        core_done  = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // req0 write; a nonzero core byte must not leak into a write response
        model_dly = 5; core_rdata = 8'hEE;
        push_l(0, 0, 7'h50, 13'h012, 2'd1, 8'hA5, 1);
        push_r(0, 0, 8'h00, 0);
        post(0, 0, 7'h50, 13'h012, 2'd1, 8'hA5);
        wait_ack(0, "wr_ack");
        @(negedge clk);
        chk("wr_mid_stable", {core_addr_me, core_addr_reg, core_wdata, core_num_sent},
            {7'h50, 13'h012, 8'hA5, 8'd1});
        wait_idle(200, "wr_idle");

        // req1 read, two-byte register address
        model_dly = 3; core_rdata = 8'h5E;
        push_l(1, 1, 7'h3C, 13'h1ABC, 2'd2, 8'h00, 1);
        push_r(1, 0, 8'h5E, 0);
        post(1, 1, 7'h3C, 13'h1ABC, 2'd2, 8'h00);
        wait_ack(1, "rd_ack");
        wait_idle(200, "rd_idle");

        // Both requesters held from reset: grants alternate starting with req0
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("reset_idle");
        rst_n = 1'b1;
        chk_gap = 1; model_dly = 4; core_rdata = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                push_l(0, 0, 7'h11, 13'h00AA, 2'd1, 8'h33, 1);
                push_r(0, 0, 8'h00, 0);
            end else begin
                push_l(1, 1, 7'h22, 13'h0155, 2'd2, 8'h44, 1);
                push_r(1, 0, 8'hC3, 0);
            end
        end
        post(0, 0, 7'h11, 13'h00AA, 2'd1, 8'h33);
        post(1, 1, 7'h22, 13'h0155, 2'd2, 8'h44);
        seen = 0;
        for (int k = 0; k < 600 && seen < 4; k++) begin
            @(negedge clk);
            if (req0_ack || req1_ack) seen++;
        end
        chk("alt_acks", seen, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle(300, "alt_idle");
        chk_gap = 0;

        // Core never completes: timeout (retried once when the retry build is used)
        model_dly = 0; core_rdata = 8'h99;
        a0 = ack0_cnt; e0 = en_cnt;
        push_l(0, 0, 7'h7F, 13'h1FFF, 2'd1, 8'h5A, 1);
        if (EXP_EN_TO == 2) push_l(0, 0, 7'h7F, 13'h1FFF, 2'd1, 8'h5A, 0);
        push_r(0, 1, 8'h00, 1);
        post(0, 0, 7'h7F, 13'h1FFF, 2'd1, 8'h5A);
        wait_ack(0, "to_ack");
        wait_idle(400, "to_idle");
        chk("to_enables", en_cnt - e0, EXP_EN_TO);
        chk("to_acks", ack0_cnt - a0, 1);

        // Done coincident with the terminal count: done wins, data captured
        model_dly = T; core_rdata = 8'h77;
        push_l(1, 1, 7'h01, 13'h0002, 2'd1, 8'h00, 1);
        push_r(1, 0, 8'h77, 0);
        post(1, 1, 7'h01, 13'h0002, 2'd1, 8'h00);
        wait_ack(1, "coin_ack");
        wait_idle(300, "coin_idle");

        // Reset during WAIT aborts silently; next request proceeds normally
        model_dly = 0;
        push_l(0, 1, 7'h2A, 13'h00F0, 2'd3, 8'h00, 1);
        post(0, 1, 7'h2A, 13'h00F0, 2'd3, 8'h00);
        wait_ack(0, "abort_ack");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("reset_wait");
        rst_n = 1'b1;
        model_dly = 2; core_rdata = 8'h12;
        push_l(1, 0, 7'h10, 13'h0020, 2'd0, 8'h99, 1);
        push_r(1, 0, 8'h00, 0);
        post(1, 0, 7'h10, 13'h0020, 2'd0, 8'h99);
        wait_ack(1, "post_reset_ack");
        wait_idle(200, "post_reset_idle");
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/iic_core_arbiter.md
# iic_core_arbiter

Round-robin arbiter and transaction sequencer that shares one I2C master core between two requesters, such as a sensor-config FSM and a host register port. Each requester posts a single-byte read or write command. The arbiter grants the core, drives its command inputs, pulses its enable, and waits for completion or timeout. It then returns a response to the owner and enforces an idle gap before the next grant. It sits between the requesters and the I2C core, and it is the only block that drives the core's command inputs.

## Interface
Parameters:
- TIMEOUT_CYC, 60000: clk cycles allowed in WAIT before a transaction is declared failed. This also covers a NACK, where the core returns to idle without pulsing done.
- GAP_CYC, 1000: minimum idle clk cycles between the end of one transaction and the next launch.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- reqN_valid  in  1  request N (N=0,1) pending; held until reqN_ack
- reqN_rd  in  1  1 = read, 0 = write
- reqN_dev  in  7  7-bit device address
- reqN_reg  in  13  register address
- reqN_reg_len  in  2  register address length in bytes; legal values 1 and 2
- reqN_wdata  in  8  write byte
- reqN_ack  out  1  one-cycle pulse: request N latched
- reqN_rsp_valid  out  1  one-cycle pulse: request N finished
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout/NACK
- rsp_rdata  out  8  read byte, qualified by rsp_valid
- core_wr_en, core_re_en  out  1  one-cycle launch pulses to the core
- core_addr_me  out  7  device address to the core
- core_addr_reg  out  13  register address to the core
- core_num_reg_add  out  2  register address length to the core
- core_num_sent  out  8  sent-byte count to the core
- core_num_rece  out  8  received-byte count to the core
- core_wdata  out  8  write byte to the core
- core_rdata  in  8  received byte from the core
- core_done  in  1  one-cycle completion pulse from the core
- busy  out  1  high in every state except IDLE

## Operation
- States and transitions:
  - IDLE: if any reqN_valid is high, go to LAUNCH.
  - LAUNCH: stay one cycle, then go to WAIT.
  - WAIT: on core_done go to RESP; on timeout go to RESP with an error.
  - RESP: stay one cycle, then go to GAP.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- Arbitration is evaluated in IDLE only.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester not granted last wins. The last_grant register resets to 1, so req0 wins the first tie.
- Latching on the IDLE→LAUNCH edge:
  - The winner's fields are latched into the core_* registers.
  - core_num_sent and core_num_rece are set to 8'd1.
  - These outputs stay stable through LAUNCH, WAIT and RESP. The core samples them mid-transaction.
- In LAUNCH:
  - reqN_ack pulses for the winner.
  - Either core_re_en or core_wr_en pulses, according to the latched rd bit.
- WAIT uses a timeout counter, cleared on entry and incremented every cycle.
  - core_done ends WAIT successfully. On a read, rsp_rdata is loaded from core_rdata; on a write, it is loaded with 8'h00. rsp_err is set to 0.
  - A counter value of TIMEOUT_CYC-1 without core_done is a timeout. rsp_rdata is set to 8'h00 and rsp_err to 1.
  - If core_done and the terminal count occur in the same cycle, done wins.
- In RESP, reqN_rsp_valid pulses for the owner only. rsp_err and rsp_rdata hold their values until the next RESP.
- A requester that drops valid before being acked is simply not granted. No error is raised.
- A reqN_reg_len value of 0 or 3 is passed through unchanged; the behaviour is the core's.
- Reset values: all outputs 0, last_grant=1, state IDLE. A reset mid-transaction aborts at once: no response is issued and the enables are deasserted.

## Timing
- reqN_valid is sampled high in IDLE at cycle t.
  - LAUNCH runs at t+1, with reqN_ack and core_*_en high for exactly one cycle.
  - WAIT runs from t+2.
- core_done at cycle d gives RESP at d+1, with reqN_rsp_valid high for one cycle.
- GAP runs from d+2 through d+1+GAP_CYC. IDLE is reached at d+2+GAP_CYC.
- A timeout is detected at the terminal count cycle; RESP follows on the next cycle.
- A new request is never launched while busy=1.

## Configuration
- IIC_ARB_RETRY_EN defined:
  - The first timeout of a transaction does not report. The arbiter goes through GAP and then LAUNCH again with the same latched fields and without a second reqN_ack.
  - A second timeout reports rsp_err=1.
  - A one-bit retry flag is cleared on every IDLE→LAUNCH.
- Not defined: the first timeout reports rsp_err=1 directly, and no retry logic is generated.

## Test plan
- req0 write (dev 0x50, reg 0x012, len 1, wdata 0xA5) → core_wr_en is one pulse. core_addr_me=0x50, core_addr_reg=0x012, core_wdata=0xA5 and core_num_sent=1 all stay stable until done. Then req0_rsp_valid pulses with rsp_err=0 and rsp_rdata=0x00.
- req1 read (dev 0x3C, reg 0x1ABC, len 2), with the core model returning 0x5E → core_re_en pulses and core_num_rece=1. The response is req1_rsp_valid, rsp_rdata=0x5E, rsp_err=0.
- req0 and req1 both valid from reset and held → grants alternate req0, req1, req0, req1. The gap between core_done and the next enable is ≥GAP_CYC+1 cycles.
- Core never pulses done → rsp_err=1 and rsp_rdata=0x00.
  - Without IIC_ARB_RETRY_EN: RESP exactly TIMEOUT_CYC cycles after WAIT entry.
  - With the macro: exactly two core enables and a single req ack.
- core_done coincident with the terminal count → rsp_err=0 and the data is captured.
- rst_n driven low for one cycle during WAIT → all outputs are 0 on the next cycle, no rsp_valid ever fires for that request, and the next request is granted normally.
